// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared FSM encoding and default sizing for the BIST session sequencer.
package bist_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT   = 3'd1,
      RUN    = 3'd2,
      SETTLE = 3'd3,
      CMP    = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam int SIG_W_DEF = 4;
   localparam int N_PAT_DEF = 31;
   localparam int CNT_W_DEF = 5;

endpackage

// File: rtl/bist_ctrl_if.sv
// rtl/bist_ctrl_if.sv - start/done handshake and LFSR/SISR control bundle of the BIST sequencer.
interface bist_ctrl_if #(
   parameter int SIG_W = 4,
   parameter int CNT_W = 5
);
   logic             start;
   logic [SIG_W-1:0] sig;
   logic             seed_ld;
   logic             run;
   logic             busy;
   logic             done;
   logic             pass;
   logic             fail;
   logic [CNT_W-1:0] pat_cnt;
   logic [SIG_W-1:0] sig_cap;

   modport master (
      output start, sig,
      input  seed_ld, run, busy, done, pass, fail, pat_cnt, sig_cap
   );

   modport slave (
      input  start, sig,
      output seed_ld, run, busy, done, pass, fail, pat_cnt, sig_cap
   );
endinterface

// File: rtl/bist_pat_cnt.sv
// rtl/bist_pat_cnt.sv - saturating pattern counter with clear/enable and a last-pattern flag.
module bist_pat_cnt #(
   parameter int N_PAT = 31,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_PAT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PAT - 1);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != CNT_MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign last = (cnt == CNT_LAST);
endmodule

// File: rtl/bist_ctrl.sv
// rtl/bist_ctrl.sv - BIST session FSM with signature compare and sticky pass/fail result.
// Optional BIST_RETRY_EN: a first-attempt mismatch reruns the session once before failing.
module bist_ctrl
   import bist_pkg::*;
#(
   parameter int               SIG_W  = SIG_W_DEF,
   parameter int               N_PAT  = N_PAT_DEF,
   parameter int               CNT_W  = CNT_W_DEF,
   parameter logic [SIG_W-1:0] GOLDEN = SIG_W'(4'hA)
) (
   input logic       clk,
   input logic       rst_b,
   bist_ctrl_if.slave bus
);
   generate
      if (N_PAT < 1 || (2 ** CNT_W) <= N_PAT) begin : g_bad_cfg
         $error("bist_ctrl: N_PAT must be >= 1 and fit in CNT_W bits");
      end
   endgenerate

   state_t state;
   state_t state_nx;
   logic   match;
   logic   cnt_clr;
   logic   cnt_en;
   logic   cnt_last;
   logic   start_acc;

   assign match     = (bus.sig == GOLDEN);
   assign start_acc = (state == IDLE) && bus.start;
   assign cnt_clr   = start_acc || (state == INIT);
   assign cnt_en    = (state == RUN);

   bist_pat_cnt #(
      .N_PAT (N_PAT),
      .CNT_W (CNT_W)
   ) u_pat_cnt (
      .clk  (clk),
      .rst_b(rst_b),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .cnt  (bus.pat_cnt),
      .last (cnt_last)
   );

`ifdef BIST_RETRY_EN
   logic retry;

   // Marks that the first attempt already mismatched; only meaningful between IDLE visits.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         retry <= 1'b0;
      end else if (state == IDLE) begin
         retry <= 1'b0;
      end else if (state == CMP && !match) begin
         retry <= 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      bus.seed_ld = 1'b0;
      bus.run     = 1'b0;
      bus.busy    = (state != IDLE);
      bus.done    = 1'b0;
      case (state)
         IDLE:   if (bus.start) state_nx = INIT;
         INIT: begin
            bus.seed_ld = 1'b1;
            state_nx    = RUN;
         end
         RUN: begin
            bus.run = 1'b1;
            if (cnt_last) state_nx = SETTLE;
         end
         SETTLE: state_nx = CMP;
         CMP: begin
            state_nx = DONE;
`ifdef BIST_RETRY_EN
            if (!match && !retry) state_nx = INIT;
`endif
         end
         DONE: begin
            bus.done = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Results persist from CMP until the next accepted start clears them.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         bus.pass    <= 1'b0;
         bus.fail    <= 1'b0;
         bus.sig_cap <= '0;
      end else if (start_acc) begin
         bus.pass    <= 1'b0;
         bus.fail    <= 1'b0;
         bus.sig_cap <= '0;
      end else if (state == CMP) begin
         bus.sig_cap <= bus.sig;
         if (match) begin
            bus.pass <= 1'b1;
`ifdef BIST_RETRY_EN
         end else if (retry) begin
            bus.fail <= 1'b1;
`else
         end else begin
            bus.fail <= 1'b1;
`endif
         end
      end
   end
endmodule

// File: tb/tb_bist_ctrl.sv
// tb/tb_bist_ctrl.sv - self-checking bench for bist_ctrl with a cycle-indexed session model.
module tb_bist_ctrl;
   localparam int         N    = 31;
   localparam int         SW   = 4;
   localparam int         CW   = 5;
   localparam logic [3:0] GOLD = 4'hA;
   localparam int         ALEN = N + 3;

`ifdef BIST_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   logic clk;
   logic rst_b;
   int   n_tests = 0;
   int   n_fail  = 0;

   bist_ctrl_if #(.SIG_W(SW), .CNT_W(CW)) bus ();

   bist_ctrl #(
      .SIG_W (SW),
      .N_PAT (N),
      .CNT_W (CW),
      .GOLDEN(GOLD)
   ) dut (
      .clk  (clk),
      .rst_b(rst_b),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".seed_ld"}, 32'(bus.seed_ld), 0);
      check({tag, ".run"},     32'(bus.run),     0);
      check({tag, ".busy"},    32'(bus.busy),    0);
      check({tag, ".done"},    32'(bus.done),    0);
      check({tag, ".pass"},    32'(bus.pass),    0);
      check({tag, ".fail"},    32'(bus.fail),    0);
      check({tag, ".pat_cnt"}, 32'(bus.pat_cnt), 0);
      check({tag, ".sig_cap"}, 32'(bus.sig_cap), 0);
   endtask

   // Expects start=1 already driven during an IDLE cycle; returns at the negedge of the
   // IDLE cycle following DONE (or right after an injected reset).
   task automatic session(input logic [3:0] s1, input logic [3:0] s2, input bit keep,
                          input int pulse_k, input int abort_k);
      int         attempts, ltot, idx, a, o, caps;
      logic [3:0] fin_sig, cap_exp;
      bit         fin_match;
      attempts  = (RETRY_EN && s1 != GOLD) ? 2 : 1;
      fin_sig   = (attempts == 2) ? s2 : s1;
      fin_match = (fin_sig == GOLD);
      ltot      = attempts * ALEN + 1;
      bus.sig   = s1;
      @(posedge clk);
      #1;
      if (!keep) bus.start = 1'b0;
      for (int k = 1; k <= ltot; k++) begin
         @(negedge clk);
         if (pulse_k != 0 && k == pulse_k + 1) bus.start = 1'b0;
         idx = k - 1;
         a   = idx / ALEN;
         o   = idx % ALEN;
         if (a == 1 && o == 0) bus.sig = s2;
         caps = idx / ALEN;
         if (caps > attempts) caps = attempts;
         cap_exp = (caps == 0) ? 4'h0 : (caps == 1) ? s1 : s2;
         if (k == ltot) begin
            check("done.done",    32'(bus.done),    1);
            check("done.seed_ld", 32'(bus.seed_ld), 0);
            check("done.run",     32'(bus.run),     0);
            check("done.pat_cnt", 32'(bus.pat_cnt), N);
            check("done.pass",    32'(bus.pass),    32'(fin_match));
            check("done.fail",    32'(bus.fail),    32'(!fin_match));
         end else begin
            check("sess.done",    32'(bus.done),    0);
            check("sess.seed_ld", 32'(bus.seed_ld), 32'(o == 0));
            check("sess.run",     32'(bus.run),     32'(o >= 1 && o <= N));
            check("sess.pat_cnt", 32'(bus.pat_cnt), (o == 0) ? 0 : (o <= N) ? o - 1 : N);
            check("sess.pass",    32'(bus.pass),    0);
            check("sess.fail",    32'(bus.fail),    0);
         end
         check("sess.busy",    32'(bus.busy),    1);
         check("sess.sig_cap", 32'(bus.sig_cap), 32'(cap_exp));
         if (k == pulse_k) bus.start = 1'b1;
         if (k == abort_k) begin
            rst_b = 1'b0;
            #1;
            check_zero("async_rst");
            return;
         end
      end
      @(negedge clk);
      check("idle.busy",    32'(bus.busy),    0);
      check("idle.done",    32'(bus.done),    0);
      check("idle.run",     32'(bus.run),     0);
      check("idle.pass",    32'(bus.pass),    32'(fin_match));
      check("idle.fail",    32'(bus.fail),    32'(!fin_match));
      check("idle.sig_cap", 32'(bus.sig_cap), 32'(fin_sig));
      check("idle.pat_cnt", 32'(bus.pat_cnt), N);
   endtask

   task automatic quiet_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("quiet.busy", 32'(bus.busy), 0);
         check("quiet.done", 32'(bus.done), 0);
      end
   endtask

   initial begin
      logic [3:0] r1, r2;
      rst_b     = 1'b0;
      bus.start = 1'b0;
      bus.sig   = 4'h0;
      #1;
      check_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      check_zero("post_reset");

      // Directed: golden match, then mismatch.
      bus.start = 1'b1;
      session(4'hA, 4'hA, 1'b0, 0, 0);
      quiet_cycles(2);
      bus.start = 1'b1;
      session(4'h3, 4'h3, 1'b0, 0, 0);
      quiet_cycles(2);

      // start while busy is ignored; only one done.
      bus.start = 1'b1;
      session(4'hA, 4'hA, 1'b0, 12, 0);
      quiet_cycles(4);

      // Asynchronous reset mid-run, then a clean full session.
      bus.start = 1'b1;
      session(4'hA, 4'hA, 1'b0, 0, 19);
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      check_zero("after_abort");
      quiet_cycles(2);
      bus.start = 1'b1;
      session(4'h3, 4'hA, 1'b0, 0, 0);
      quiet_cycles(1);

      // start held high: back-to-back sessions with results cleared each restart.
      bus.start = 1'b1;
      session(4'h3, 4'h3, 1'b1, 0, 0);
      session(4'hA, 4'hA, 1'b1, 0, 0);
      session(4'h5, 4'hA, 1'b0, 0, 0);
      quiet_cycles(2);

      // Retry-oriented pairs (single attempt when the retry feature is absent).
      bus.start = 1'b1;
      session(4'h3, 4'hA, 1'b0, 0, 0);
      bus.start = 1'b1;
      session(4'h3, 4'h3, 1'b0, 0, 0);

      // Randomized signatures, biased towards the golden value.
      for (int i = 0; i < 8; i++) begin
         r1 = ($urandom_range(0, 2) == 0) ? GOLD : 4'($urandom_range(0, 15));
         r2 = ($urandom_range(0, 1) == 0) ? GOLD : 4'($urandom_range(0, 15));
         quiet_cycles($urandom_range(0, 3));
         bus.start = 1'b1;
         session(r1, r2, 1'b0, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
